// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: CPU load/store unit mastering a word-organised data memory; sub-word stores use read-modify-write.
module lsu_dmem_master #(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] mem_adrs,
  output logic [N-1:0] mem_data_w,
  output logic         mem_WE,
  input  logic [N-1:0] mem_data_r
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [M-1:0] a_addr;
  logic [N-1:0] a_wdata, rmw_q, lw, mask;
  logic [2:0]   a_f3;
  logic         a_err, bad;
  logic [7:0]   b;
  logic [15:0]  h;
  logic [4:0]   sh;
  assign bad = (we ? funct3 > 3'b010 : (funct3 == 3'b011 || funct3[2:1] == 2'b11))
             || (funct3[1:0] == 2'b01 && addr[0])
             || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      rdata   <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_f3    <= '0;
      a_err   <= 1'b0;
      rmw_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        a_addr  <= addr[M-1:0];
        a_wdata <= wdata;
        a_f3    <= funct3;
        a_err   <= bad;
      end
      if (state == RMW_RD) rmw_q <= mem_data_r;
      if (state == LOAD) rdata <= lw;
    end
  always_comb begin
    state_n = state == IDLE   ? (req ? (bad ? DONE : !we ? LOAD : funct3 == 3'b010 ? WRITE : RMW_RD) : IDLE)
            : state == RMW_RD ? WRITE
            : state == DONE   ? IDLE
            : DONE;
    sh = {a_addr[1:0], 3'b000};
    b = 8'(mem_data_r >> sh);
    h = 16'(mem_data_r >> {a_addr[1], 4'b0000});
    lw = a_f3[1:0] == 2'b00 ? {{(N-8){b[7] & ~a_f3[2]}}, b}
       : a_f3[1:0] == 2'b01 ? {{(N-16){h[15] & ~a_f3[2]}}, h}
       : mem_data_r;
    mask = a_f3[0] ? {{(N-16){1'b0}}, 16'hFFFF} : {{(N-8){1'b0}}, 8'hFF};
    // sub-word stores merge the lane into the word captured in RMW_RD
    mem_data_w = state != WRITE ? '0
               : a_f3[1] ? a_wdata
               : (rmw_q & ~(mask << sh)) | ((a_wdata & mask) << sh);
    mem_WE   = state == WRITE;
    mem_adrs = (state == LOAD || state == RMW_RD || state == WRITE) ? a_addr : '0;
    busy     = state != IDLE;
    done     = state == DONE;
    err      = done & a_err;
  end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: directed vector table plus reset-abort and back-to-back request sequences.
module tb_lsu_dmem_master;
  logic        clk = 0, rst = 1, req = 0, we = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, mem_data_w, mem_data_r;
  logic        busy, done, err, mem_WE;
  logic [9:0]  mem_adrs;
  logic [31:0] mem [256];
  int n_vec = 0, n_bad = 0;

  lsu_dmem_master #(.N(32), .M(10)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .mem_adrs(mem_adrs),
    .mem_data_w(mem_data_w), .mem_WE(mem_WE), .mem_data_r(mem_data_r)
  );

  always #5 clk = ~clk;
  assign mem_data_r = mem[mem_adrs[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_adrs[9:2]] <= mem_data_w;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          wes;
    logic [31:0] chk_addr, chk_word;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int lat = 0, wes = 0;
    logic busy_ok = 1, err_s = 0;
    logic [31:0] rd_s = 0;
    @(negedge clk);
    req = 1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      wes += int'(mem_WE);
      if (!busy) busy_ok = 0;
      if (done) begin
        lat = c; err_s = err; rd_s = rdata;
        break;
      end
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " err"}, {31'b0, err_s}, {31'b0, v.err});
    chk({tag, " rdata"}, rd_s, v.rdata);
    chk({tag, " mem_WE cycles"}, wes, v.wes);
    chk({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({tag, " done one cycle"}, {30'b0, done, busy}, 32'd0);
    chk({tag, " mem word"}, mem[v.chk_addr[9:2]], v.chk_word);
  endtask

  vec_t vt [19];

  initial begin
    int cnt, lat;
    logic ok;
    vt[0]  = '{1, 3'b010, 32'h010, 32'hDEADBEEF, 2, 0, 32'h0,        1, 32'h010, 32'hDEADBEEF};
    vt[1]  = '{0, 3'b010, 32'h010, 32'h0,        2, 0, 32'hDEADBEEF, 0, 32'h010, 32'hDEADBEEF};
    vt[2]  = '{1, 3'b010, 32'h010, 32'h11223344, 2, 0, 32'hDEADBEEF, 1, 32'h010, 32'h11223344};
    vt[3]  = '{1, 3'b000, 32'h012, 32'h000000AA, 3, 0, 32'hDEADBEEF, 1, 32'h010, 32'h11AA3344};
    vt[4]  = '{0, 3'b000, 32'h012, 32'h0,        2, 0, 32'hFFFFFFAA, 0, 32'h010, 32'h11AA3344};
    vt[5]  = '{0, 3'b100, 32'h012, 32'h0,        2, 0, 32'h000000AA, 0, 32'h010, 32'h11AA3344};
    vt[6]  = '{1, 3'b010, 32'h014, 32'h0,        2, 0, 32'h000000AA, 1, 32'h014, 32'h0};
    vt[7]  = '{1, 3'b001, 32'h016, 32'h00008001, 3, 0, 32'h000000AA, 1, 32'h014, 32'h80010000};
    vt[8]  = '{0, 3'b001, 32'h016, 32'h0,        2, 0, 32'hFFFF8001, 0, 32'h014, 32'h80010000};
    vt[9]  = '{0, 3'b101, 32'h016, 32'h0,        2, 0, 32'h00008001, 0, 32'h014, 32'h80010000};
    vt[10] = '{0, 3'b010, 32'h013, 32'h0,        1, 1, 32'h00008001, 0, 32'h010, 32'h11AA3344};
    vt[11] = '{1, 3'b001, 32'h011, 32'h00005555, 1, 1, 32'h00008001, 0, 32'h010, 32'h11AA3344};
    vt[12] = '{0, 3'b011, 32'h010, 32'h0,        1, 1, 32'h00008001, 0, 32'h010, 32'h11AA3344};
    vt[13] = '{1, 3'b100, 32'h010, 32'h000000FF, 1, 1, 32'h00008001, 0, 32'h010, 32'h11AA3344};
    vt[14] = '{0, 3'b000, 32'h017, 32'h0,        2, 0, 32'hFFFFFF80, 0, 32'h014, 32'h80010000};
    vt[15] = '{0, 3'b100, 32'h015, 32'h0,        2, 0, 32'h00000000, 0, 32'h014, 32'h80010000};
    vt[16] = '{1, 3'b000, 32'h013, 32'h000001FF, 3, 0, 32'h00000000, 1, 32'h010, 32'hFFAA3344};
    vt[17] = '{0, 3'b010, 32'h010, 32'h0,        2, 0, 32'hFFAA3344, 0, 32'h010, 32'hFFAA3344};
    vt[18] = '{0, 3'b001, 32'h012, 32'h0,        2, 0, 32'hFFFFFFAA, 0, 32'h010, 32'hFFAA3344};

    #1;
    chk("reset outputs", {busy, done, err, mem_WE, 28'b0}, 32'd0);
    chk("reset mem_adrs", {22'b0, mem_adrs}, 32'd0);
    chk("reset mem_data_w", mem_data_w, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    for (int i = 0; i < 19; i++) run(vt[i], $sformatf("v%0d", i));

    // reset while SB sits in RMW_RD
    @(negedge clk);
    req = 1; we = 1; funct3 = 3'b000; addr = 32'h010; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    chk("rmw_rd busy", {31'b0, busy}, 32'd1);
    chk("rmw_rd mem_WE", {31'b0, mem_WE}, 32'd0);
    chk("rmw_rd mem_adrs", {22'b0, mem_adrs}, 32'h010);
    rst = 1;
    #1;
    chk("abort outputs", {busy, done, err, mem_WE, 28'b0}, 32'd0);
    chk("abort mem_adrs", {22'b0, mem_adrs}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(done) + int'(mem_WE) + int'(busy);
    end
    chk("abort no activity", cnt, 0);
    chk("abort word kept", mem[4], 32'hFFAA3344);
    run('{0, 3'b010, 32'h010, 32'h0, 2, 0, 32'hFFAA3344, 0, 32'h010, 32'hFFAA3344}, "post-abort");

    // req held high: LW then SW, second accepted only after the DONE cycle
    @(negedge clk);
    req = 1; we = 0; funct3 = 3'b010; addr = 32'h014;
    @(posedge clk);
    ok = 1; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!busy) ok = 0;
      if (done) begin lat = c; break; end
    end
    chk("held lw latency", lat, 2);
    chk("held lw busy", {31'b0, ok}, 32'd1);
    chk("held lw rdata", rdata, 32'h80010000);
    we = 1; addr = 32'h018; wdata = 32'h12345678;
    @(negedge clk);
    chk("held idle gap busy", {31'b0, busy}, 32'd0);
    ok = 1; lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!busy) ok = 0;
      if (done) begin lat = c; break; end
    end
    req = 0;
    chk("held sw latency", lat, 2);
    chk("held sw busy", {31'b0, ok}, 32'd1);
    chk("held sw word", mem[6], 32'h12345678);
    chk("held sw rdata kept", rdata, 32'h80010000);
    @(negedge clk);
    @(negedge clk);
    chk("held final idle", {30'b0, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have parameter N, default 32, meaning data word width.
REQ-002 SHALL have parameter M, default 10, meaning memory byte-address width.
REQ-003 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have req  input  1  CPU access request, sampled only in IDLE.
REQ-006 SHALL have we  input  1  1 = store, 0 = load.
REQ-007 SHALL have funct3  input  3  RISC-V size code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have addr  input  N  byte address from CPU.
REQ-009 SHALL have wdata  input  N  store data, right-aligned.
REQ-010 SHALL have rdata  output  N  load result, extended to N bits.
REQ-011 SHALL have busy  output  1  high in every state except IDLE.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.
REQ-013 SHALL have err  output  1  misaligned or illegal access flag, valid while done=1.
REQ-014 SHALL have mem_adrs  output  M  byte address to data memory; memory indexes words by mem_adrs/4.
REQ-015 SHALL have mem_data_w  output  N  word written to memory.
REQ-016 SHALL have mem_WE  output  1  memory write enable, sampled by memory on rising edge.
REQ-017 SHALL have mem_data_r  input  N  combinational word read from memory at mem_adrs.

Function
REQ-018 SHALL implement states IDLE, LOAD, RMW_RD, WRITE, DONE.
REQ-019 SHALL, at the edge where state=IDLE and req=1, latch addr, wdata, funct3 and we; req is ignored in all other states.
REQ-020 SHALL flag err for: halfword with addr[0]=1; word with addr[1:0]!=00; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-021 SHALL, for err accesses, go IDLE->DONE with err=1, mem_WE never asserted, rdata unchanged.
REQ-022 SHALL, for loads, go IDLE->LOAD->DONE; in LOAD drive mem_adrs=latched addr[M-1:0], mem_WE=0; at LOAD exit edge register rdata.
REQ-023 SHALL select byte mem_data_r[8*addr[1:0]+7 -: 8] for LB/LBU and half mem_data_r[16*addr[1]+15 -: 16] for LH/LHU; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-024 SHALL, for SW, go IDLE->WRITE->DONE with mem_WE=1 and mem_data_w=latched wdata during WRITE only.
REQ-025 SHALL, for SB/SH, go IDLE->RMW_RD->WRITE->DONE: RMW_RD reads with mem_WE=0 and registers mem_data_r; WRITE drives the registered word with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
REQ-026 SHALL drive mem_adrs=latched addr in LOAD, RMW_RD, WRITE; mem_data_w=0 and mem_WE=0 outside WRITE.
REQ-027 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; a req high in DONE is not accepted until the following IDLE edge.
REQ-028 SHALL have latency from accepting edge to done: 1 cycle error, 2 cycles load/SW, 3 cycles SB/SH.
REQ-029 SHALL assert mem_WE for exactly one cycle per store, never for loads.
REQ-030 SHALL hold rdata from the last completed load until the next load completes; stores do not alter rdata.

Reset
REQ-031 SHALL, while rst=1, force state=IDLE, rdata=0, busy=0, done=0, err=0, mem_adrs=0, mem_data_w=0, mem_WE=0 immediately.
REQ-032 SHALL abort any access in progress on rst; no mem_WE pulse and no done pulse for the aborted access after rst deasserts.

Verification
REQ-033 SHALL pass: SW addr=0x010 wdata=0xDEADBEEF, then LW addr=0x010 -> mem_WE one cycle, done 2 cycles after each accept, rdata=0xDEADBEEF.
REQ-034 SHALL pass: word 0x010=0x11223344, SB addr=0x012 wdata=0xAA -> 3-cycle latency, word becomes 0x11AA3344; LB 0x012 -> rdata=0xFFFFFFAA; LBU 0x012 -> 0x000000AA.
REQ-035 SHALL pass: SH addr=0x016 wdata=0x8001 over word 0 -> word at 0x014 = 0x80010000; LH 0x016 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-036 SHALL pass: LW addr=0x013 and SH addr=0x011 -> done after 1 cycle with err=1, mem_WE stays 0, rdata unchanged.
REQ-037 SHALL pass: rst asserted during RMW_RD of SB -> outputs at reset values immediately, target word unchanged, no done; next LW completes normally.
REQ-038 SHALL pass: req held high continuously for LW then SW -> second access accepted only after done cycle, busy high throughout each access.
